ps2_key_rx: RTL and testbench

Decodes a raw PS/2 keyboard line (clock/data, e.g. from USER_IN) into the 11-bit toggle-strobed `ps2_key` event word consumed by the core's keyboard mapping logic. It is the producing end of that interface and replaces the HPS-supplied word when a physical keyboard is wired to the user port. The block filters and samples the PS/2 serial frame, checks it, folds E0/F0 prefixes into flags, and emits one event per make or break code.

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_line_filter.sv | 40 ++++
 rtl/ps2_key_rx.sv | 127 ++++++++++++
 tb/tb_ps2_key_rx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;

  localparam int KEY_TOG = 10;
  localparam int KEY_PRS = 9;
  localparam int KEY_EXT = 8;

  function automatic logic is_response(input logic [7:0] code);
    return (code == PS2_BAT_OK) || (code == PS2_ACK) ||
           (code == PS2_RESEND) || (code == PS2_ECHO);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchronizer plus glitch filter: output follows the line only after
// FILT_LEN consecutive identical synchronized samples. Idles high.
module ps2_line_filter #(
  parameter int FILT_LEN = 8
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic line_raw,
  output logic line_filt
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FILT_LEN - 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync_1    <= 1'b1;
      sync_2    <= 1'b1;
      line_filt <= 1'b1;
      cnt       <= CNT_LOAD;
    end else begin
      sync_1 <= line_raw;
      sync_2 <= sync_1;
      // Any sample agreeing with the current output restarts the run.
      if (sync_2 == line_filt) begin
        cnt <= CNT_LOAD;
      end else if (cnt == '0) begin
        line_filt <= sync_2;
        cnt       <= CNT_LOAD;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver producing the toggle-strobed 11-bit ps2_key word.
// Define PS2_PARITY_CHK_EN to reject frames with bad odd parity.
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 48_000_000,
  parameter int TIMEOUT_US = 100,
  parameter int FILT_LEN   = 8
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk_in,
  input  logic        ps2_dat_in,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int WD_LIMIT = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int WD_W     = $clog2(WD_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(WD_LIMIT - 1);

  logic            clk_f;
  logic            dat_f;
  logic            clk_f_d;
  logic            strobe;
  logic            frame_ok;
  ps2_state_t      state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            ext;
  logic            brk;
  logic [WD_W-1:0] wd;

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .line_raw  (ps2_clk_in),
    .line_filt (clk_f)
  );

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_dat_filt (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .line_raw  (ps2_dat_in),
    .line_filt (dat_f)
  );

  assign strobe = clk_f_d & ~clk_f;

`ifdef PS2_PARITY_CHK_EN
  logic par_bit;
  assign frame_ok = dat_f & (^shift ^ par_bit);
`else
  assign frame_ok = dat_f;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_f_d   <= 1'b1;
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      wd        <= WD_LOAD;
      ps2_key   <= '0;
      frame_err <= 1'b0;
`ifdef PS2_PARITY_CHK_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      clk_f_d   <= clk_f;
      frame_err <= 1'b0;
      if (state == IDLE) begin
        wd <= WD_LOAD;
        if (strobe && !dat_f) begin
          state   <= DATA;
          bit_cnt <= '0;
        end
      end else if (strobe) begin
        // A strobe always beats a coincident watchdog terminal count.
        wd <= WD_LOAD;
        case (state)
          DATA: begin
            shift   <= {dat_f, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
`ifdef PS2_PARITY_CHK_EN
            par_bit <= dat_f;
`endif
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!frame_ok) begin
              frame_err <= 1'b1;
              ext       <= 1'b0;
              brk       <= 1'b0;
            end else if (shift == PS2_EXT) begin
              ext <= 1'b1;
            end else if (shift == PS2_BRK) begin
              brk <= 1'b1;
            end else if (!(is_response(shift) && !ext && !brk)) begin
              ps2_key[KEY_TOG] <= ~ps2_key[KEY_TOG];
              ps2_key[KEY_PRS] <= ~brk;
              ps2_key[KEY_EXT] <= ext;
              ps2_key[7:0]     <= shift;
              ext              <= 1'b0;
              brk              <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (wd == '0) begin
        state     <= IDLE;
        frame_err <= 1'b1;
        ext       <= 1'b0;
        brk       <= 1'b0;
      end else begin
        wd <= wd - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Self-checking bench: directed PS/2 frames plus random traffic against an event-level model.
module tb_ps2_key_rx;

  localparam int FILT = 8;
  localparam int H    = 24;
  localparam int WD   = 48_000_000 / 1_000_000 * 100;
`ifdef PS2_PARITY_CHK_EN
  localparam bit PAR_CHK = 1'b1;
`else
  localparam bit PAR_CHK = 1'b0;
`endif

  logic        clk_sys    = 1'b0;
  logic        reset_n    = 1'b0;
  logic        ps2_clk_in = 1'b1;
  logic        ps2_dat_in = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  int          errors  = 0;
  int          checks  = 0;
  bit          busy    = 1'b0;
  logic [10:0] exp_key = '0;
  bit          m_ext   = 1'b0;
  bit          m_brk   = 1'b0;
  int          exp_err = 0;
  int          exp_tog = 0;
  int          dut_err = 0;
  int          dut_tog = 0;
  logic        prev_tog = 1'b0;
  logic        prev_err = 1'b0;

  ps2_key_rx dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_key    (ps2_key),
    .frame_err  (frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation still running at %0t, required finished", $time);
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // Event-level model: what one received byte (or rejection) does to the key word.
  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      exp_err++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if ((b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE) && !m_ext && !m_brk) begin
      // response code with nothing pending: dropped
    end else begin
      exp_key = {~exp_key[10], ~m_brk, m_ext, b};
      exp_tog++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  // Drives nbits of a frame (11 = complete); optional filter-length-minus-one glitch before bit glitch_bit.
  task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit stop_val,
                            input int nbits, input int glitch_bit);
    logic [10:0] bits;
    bit ok;
    bits = {stop_val, ~(^b) ^ par_flip, b, 1'b0};
    ok   = stop_val && (!PAR_CHK || !par_flip);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat_in = bits[i];
      wait_clk(H);
      if (i == glitch_bit) begin
        ps2_clk_in = 1'b0;
        wait_clk(FILT - 1);
        ps2_clk_in = 1'b1;
        wait_clk(H);
      end
      if (i == 10) busy = 1'b1;
      ps2_clk_in = 1'b0;
      if (i == 10) begin
        wait_clk(FILT + 6);
        model_byte(b, ok);
        busy = 1'b0;
        wait_clk(H - FILT - 6);
      end else begin
        wait_clk(H);
      end
      ps2_clk_in = 1'b1;
    end
    if (nbits == 11) begin
      ps2_dat_in = 1'b1;
      wait_clk(2);
      check("err_count", dut_err, exp_err);
      check("toggle_count", dut_tog, exp_tog);
    end
  endtask

  always @(negedge clk_sys) begin
    if (!reset_n) begin
      check("reset_key", ps2_key, 11'h000);
      check("reset_err", frame_err, 1'b0);
      prev_tog = 1'b0;
      prev_err = 1'b0;
    end else begin
      if (!busy) check("key", ps2_key, exp_key);
      if (ps2_key[10] !== prev_tog) dut_tog++;
      prev_tog = ps2_key[10];
      if (frame_err) begin
        dut_err++;
        check("err_pulse_width", prev_err, 1'b0);
      end
      prev_err = frame_err;
    end
  end

  initial begin
    wait_clk(5);
    reset_n = 1'b1;
    wait_clk(20);

    send_frame(8'h29, 0, 1, 11, -1);
    check("lit_make_29", ps2_key, 11'h629);

    send_frame(8'hF0, 0, 1, 11, -1);
    send_frame(8'h29, 0, 1, 11, -1);
    check("lit_break_29", ps2_key, 11'h029);

    send_frame(8'hE0, 0, 1, 11, -1);
    send_frame(8'h75, 0, 1, 11, -1);
    check("lit_ext_make_75", ps2_key, 11'h775);
    send_frame(8'hE0, 0, 1, 11, -1);
    send_frame(8'hF0, 0, 1, 11, -1);
    send_frame(8'h75, 0, 1, 11, -1);
    check("lit_ext_break_75", ps2_key, 11'h175);

    send_frame(8'h14, 1, 1, 11, -1);
    check("lit_bad_parity_14", ps2_key, PAR_CHK ? 11'h175 : 11'h614);

    send_frame(8'hAA, 0, 1, 11, -1);
    send_frame(8'h3C, 0, 0, 11, -1);

    send_frame(8'h55, 0, 1, 5, -1);
    wait_clk(WD + 300);
    model_byte(8'h00, 1'b0);
    check("timeout_err_count", dut_err, exp_err);
    send_frame(8'h6B, 0, 1, 11, -1);
    check("lit_after_timeout_6b", {22'd0, ps2_key[9:0]}, 32'h26B);

    send_frame(8'h33, 0, 1, 4, -1);
    wait_clk(3);
    exp_key = '0;
    m_ext   = 1'b0;
    m_brk   = 1'b0;
    reset_n = 1'b0;
    ps2_clk_in = 1'b1;
    ps2_dat_in = 1'b1;
    #1;
    check("lit_async_reset_key", ps2_key, 11'h000);
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(20);

    ps2_dat_in = 1'b0;
    ps2_clk_in = 1'b0;
    wait_clk(FILT - 1);
    ps2_clk_in = 1'b1;
    wait_clk(H);
    ps2_dat_in = 1'b1;
    wait_clk(H);
    send_frame(8'h1C, 0, 1, 11, 4);
    check("lit_after_glitch_1c", ps2_key, 11'h61C);

    for (int n = 0; n < 40; n++) begin
      int          kind;
      logic [7:0]  b;
      logic [31:0] r;
      kind = $urandom_range(0, 9);
      r    = $urandom;
      case (kind)
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: case (r[1:0])
             2'd0: b = 8'hAA;
             2'd1: b = 8'hFA;
             2'd2: b = 8'hFE;
             default: b = 8'hEE;
           endcase
        default: b = r[15:8];
      endcase
      send_frame(b, $urandom_range(0, 7) == 0, $urandom_range(0, 9) != 0, 11, -1);
      wait_clk($urandom_range(0, 60));
    end

    wait_clk(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
